// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS front-end sequencer.
// Provides the sequencer state encoding and the default reset PC.
package mips_pkg;

    // Sequencer modes: stopped, free-running, or one-shot step.
    typedef enum logic [1:0] {
        S_HALT = 2'd0,
        S_RUN  = 2'd1,
        S_STEP = 2'd2
    } seq_state_t;

    localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;

    // Word-aligned form of an address.
    function automatic logic [31:0] word_align(
        input logic [31:0] addr
    );
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/sync_rise.sv
// Multi-flop synchroniser for an asynchronous level input
// with a registered-history rising-edge detector.
//
// Ports:
//   clk       system clock
//   reset     asynchronous active-low reset
//   async_in  raw asynchronous level
//   sync_out  synchronised level
//   rise      one-cycle pulse on a 0->1 of sync_out
module sync_rise #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_out = sync_q[SYNC_STAGES-1];
    assign rise     = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter stage feeding the single-cycle datapath:
// run / single-step / halt control with a PC breakpoint.
//
// Ports:
//   clk, reset      clock, async active-low reset
//   pc_next         next PC from the datapath
//   run_req         async run switch (level)
//   step_btn        async step button (rising edge acts)
//   bp_en, bp_addr  breakpoint enable and address
//   pc              current PC
//   exec_en         cycle commits the instruction at pc
//   halted          sequencer is stopped
//   bp_hit          sticky breakpoint indicator
//   retired         committed-instruction count
module pc_sequencer
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = MIPS_RESET_PC,
    parameter int          SYNC_STAGES = 2,
    parameter int          CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [31:0]      pc_next,
    input  logic             run_req,
    input  logic             step_btn,
    input  logic             bp_en,
    input  logic [31:0]      bp_addr,
    output logic [31:0]      pc,
    output logic             exec_en,
    output logic             halted,
    output logic             bp_hit,
    output logic [CNT_W-1:0] retired
);

    seq_state_t       state_q;
    seq_state_t       state_d;
    logic [31:0]      pc_q;
    logic [CNT_W-1:0] ret_q;
    logic             bp_hit_q;

    logic run_s;
    logic run_rise;
    logic step_s;
    logic step_rise;
    logic bp_match;
    logic set_bp;
    logic clr_bp;

    // Only word addresses matter; low bits are dropped.
    logic unused_bits;
    assign unused_bits = ^{pc_next[1:0], bp_addr[1:0], step_s};

    sync_rise #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_run_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(run_req),
        .sync_out(run_s),
        .rise    (run_rise)
    );

    sync_rise #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_step_sync (
        .clk     (clk),
        .reset   (reset),
        .async_in(step_btn),
        .sync_out(step_s),
        .rise    (step_rise)
    );

    assign exec_en = (state_q == S_RUN) | (state_q == S_STEP);
    assign halted  = (state_q == S_HALT);

    // Match on the committing instruction's successor, so the
    // halted PC equals bp_addr with that instruction unexecuted.
    assign bp_match = exec_en & bp_en
                    & (pc_next[31:2] == bp_addr[31:2]);

    always_comb begin
        state_d = state_q;
        set_bp  = 1'b0;
        clr_bp  = 1'b0;
        unique case (state_q)
            S_HALT: begin
                if (run_rise) begin
                    state_d = S_RUN;
                    clr_bp  = 1'b1;
                end else if (step_rise) begin
                    state_d = S_STEP;
                    clr_bp  = 1'b1;
                end
            end
            S_RUN: begin
                if (bp_match) begin
                    state_d = S_HALT;
                    set_bp  = 1'b1;
                end else if (!run_s) begin
                    state_d = S_HALT;
                end
            end
            S_STEP: begin
                state_d = S_HALT;
                set_bp  = bp_match;
            end
            default: state_d = S_HALT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_HALT;
            pc_q     <= RESET_PC;
            ret_q    <= '0;
            bp_hit_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (exec_en) begin
                pc_q  <= word_align(pc_next);
                ret_q <= ret_q + CNT_W'(1);
            end
            if (clr_bp) begin
                bp_hit_q <= 1'b0;
            end else if (set_bp) begin
                bp_hit_q <= 1'b1;
            end
        end
    end

    assign pc      = pc_q;
    assign retired = ret_q;
    assign bp_hit  = bp_hit_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios
// plus randomized run/step/breakpoint traffic vs a model.
module tb_pc_sequencer;

    localparam int SYNC = 2;
    localparam int CW   = 32;

    localparam int M_HALT = 0;
    localparam int M_RUN  = 1;
    localparam int M_STEP = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc_next;
    logic          run_req;
    logic          step_btn;
    logic          bp_en;
    logic [31:0]   bp_addr;
    logic [31:0]   pc;
    logic          exec_en;
    logic          halted;
    logic          bp_hit;
    logic [CW-1:0] retired;

    always #5 clk = ~clk;

    pc_sequencer #(
        .RESET_PC   (32'h0),
        .SYNC_STAGES(SYNC),
        .CNT_W      (CW)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .pc_next (pc_next),
        .run_req (run_req),
        .step_btn(step_btn),
        .bp_en   (bp_en),
        .bp_addr (bp_addr),
        .pc      (pc),
        .exec_en (exec_en),
        .halted  (halted),
        .bp_hit  (bp_hit),
        .retired (retired)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(
        input string       tag,
        input logic [31:0] got,
        input logic [31:0] exp
    );
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    // Reference model: mode, architectural PC, counter, sticky
    // flag, and a delay line of sampled switch levels.
    int          mode;
    logic [31:0] m_pc;
    logic [31:0] m_ret;
    bit          m_bp;
    bit          rq[$];
    bit          sq[$];

    function automatic void m_reset();
        mode  = M_HALT;
        m_pc  = 32'h0;
        m_ret = 32'h0;
        m_bp  = 1'b0;
        rq.delete();
        sq.delete();
        for (int i = 0; i <= SYNC; i++) begin
            rq.push_back(1'b0);
            sq.push_back(1'b0);
        end
    endfunction

    function automatic void model_edge();
        bit rs, rd, ss, sd, commit, match;
        rs     = rq[SYNC-1];
        rd     = rq[SYNC];
        ss     = sq[SYNC-1];
        sd     = sq[SYNC];
        commit = (mode != M_HALT);
        match  = commit && bp_en
              && (pc_next[31:2] == bp_addr[31:2]);
        if (commit) begin
            m_pc  = pc_next & 32'hFFFF_FFFC;
            m_ret = m_ret + 1;
        end
        case (mode)
            M_HALT: begin
                if (rs && !rd) begin
                    mode = M_RUN;
                    m_bp = 1'b0;
                end else if (ss && !sd) begin
                    mode = M_STEP;
                    m_bp = 1'b0;
                end
            end
            M_RUN: begin
                if (match) begin
                    mode = M_HALT;
                    m_bp = 1'b1;
                end else if (!rs) begin
                    mode = M_HALT;
                end
            end
            default: begin
                mode = M_HALT;
                if (match) m_bp = 1'b1;
            end
        endcase
        rq.push_front(run_req);
        void'(rq.pop_back());
        sq.push_front(step_btn);
        void'(sq.pop_back());
    endfunction

    task automatic check_all();
        chk("pc", pc, m_pc);
        chk("exec_en", 32'(exec_en), 32'(mode != M_HALT));
        chk("halted", 32'(halted), 32'(mode == M_HALT));
        chk("bp_hit", 32'(bp_hit), 32'(m_bp));
        chk("retired", retired, m_ret);
    endtask

    task automatic tick();
        @(posedge clk);
        if (reset) model_edge();
        #1;
        check_all();
        pc_next = m_pc + 32'd4;
    endtask

    task automatic apply_reset(input int n);
        reset    = 1'b0;
        run_req  = 1'b0;
        step_btn = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = 32'h0;
        m_reset();
        repeat (n) tick();
        reset = 1'b1;
    endtask

    int ex_cnt;
    int guard;

    initial begin
        reset    = 1'b0;
        run_req  = 1'b0;
        step_btn = 1'b0;
        bp_en    = 1'b0;
        bp_addr  = 32'h0;
        pc_next  = 32'h4;
        m_reset();
        #1;
        check_all();

        // Reset then idle
        apply_reset(3);
        repeat (10) tick();
        chk("idle_pc", pc, 32'h0);
        chk("idle_ret", retired, 32'h0);

        // Free run with latency check
        run_req = 1'b1;
        repeat (SYNC) tick();
        chk("lat_pre", 32'(exec_en), 32'h0);
        tick();
        chk("lat_on", 32'(exec_en), 32'h1);
        repeat (5) tick();
        chk("run_pc", pc, 32'h14);
        chk("run_ret", retired, 32'h5);
        run_req = 1'b0;
        repeat (SYNC + 2) tick();
        chk("stop_halt", 32'(halted), 32'h1);

        // Single step, three pulses
        apply_reset(2);
        ex_cnt = 0;
        for (int p = 0; p < 3; p++) begin
            step_btn = 1'b1;
            repeat (4) begin
                tick();
                if (exec_en) ex_cnt++;
            end
            step_btn = 1'b0;
            repeat (6) begin
                tick();
                if (exec_en) ex_cnt++;
            end
        end
        chk("step_cnt", 32'(ex_cnt), 32'h3);
        chk("step_pc", pc, 32'hC);
        chk("step_ret", retired, 32'h3);

        // Breakpoint and resume
        apply_reset(2);
        bp_en   = 1'b1;
        bp_addr = 32'h10;
        run_req = 1'b1;
        repeat (20) tick();
        chk("bp_pc", pc, 32'h10);
        chk("bp_flag", 32'(bp_hit), 32'h1);
        chk("bp_ret", retired, 32'h4);
        chk("bp_halt", 32'(halted), 32'h1);
        run_req = 1'b0;
        repeat (4) tick();
        run_req = 1'b1;
        repeat (SYNC + 2) tick();
        chk("bp_clr", 32'(bp_hit), 32'h0);
        chk("bp_go", 32'(halted), 32'h0);
        chk("bp_next", pc, 32'h14);
        run_req = 1'b0;
        bp_en   = 1'b0;
        repeat (6) tick();

        // Run beats step; alignment of pc_next
        apply_reset(2);
        run_req  = 1'b1;
        step_btn = 1'b1;
        repeat (SYNC + 5) tick();
        chk("prio_run", 32'(halted), 32'h0);
        pc_next = 32'h0000_0023;
        tick();
        chk("align", pc, 32'h20);
        run_req  = 1'b0;
        step_btn = 1'b0;
        repeat (6) tick();

        // Asynchronous reset mid-run
        apply_reset(2);
        run_req = 1'b1;
        guard   = 0;
        while (m_pc != 32'h40 && guard < 60) begin
            tick();
            guard++;
        end
        chk("reach40", pc, 32'h40);
        #2;
        reset = 1'b0;
        #1;
        m_reset();
        chk("ar_pc", pc, 32'h0);
        chk("ar_halt", 32'(halted), 32'h1);
        chk("ar_ret", retired, 32'h0);
        chk("ar_ex", 32'(exec_en), 32'h0);
        run_req = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        tick();
        chk("rel_ret", retired, 32'h0);
        chk("rel_pc", pc, 32'h0);

        // Randomized traffic
        apply_reset(2);
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) run_req = ~run_req;
            if ($urandom_range(0, 7) == 0) step_btn = ~step_btn;
            if ($urandom_range(0, 63) == 0) begin
                bp_en   = 1'($urandom_range(0, 1));
                bp_addr = 32'($urandom_range(0, 255));
            end
            if ($urandom_range(0, 4) == 0) begin
                pc_next = 32'($urandom_range(0, 255));
            end
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
